axi_lite_cmd_master: RTL and testbench

- AXI4-Lite initiator (manager) that converts a simple single-beat command stream into AXI4-Lite read or write transactions.
- It is the issuing end of the AXI-Lite links the SoC peripherals answer on (UART, control registers).
- Used by the boot/debug loader and by test sequencers to reach those peripherals without a full AXI4 master.
- Exactly one transaction is outstanding at a time; each result is returned on a response stream.

---
 rtl/axi_lite_cmd_master_if.sv | 82 ++++++++
 rtl/axi_lite_cmd_master.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmd_master_if.sv
// Bundle of the command/response streams and the five AXI4-Lite channels
// served by axi_lite_cmd_master.
//   master modport: the initiator's view (accepts commands, drives AXI requests).
//   slave  modport: the environment's view (issues commands, answers AXI requests).
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Command stream
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  // Response stream
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  // AXI4-Lite write address / data / response
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  // AXI4-Lite read address / data
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single-beat read/write commands into AXI4-Lite
// transactions, one outstanding at a time, and returns each result on the
// response stream.
// Optional response-wait timeout: define AXI_LITE_CMD_MASTER_TIMEOUT_EN.
// Without it, waits for B/R are unbounded and rsp_timeout is always 0.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_lite_cmd_master_if.master  bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_lite_cmd_master: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    RSP
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    , DRAIN
`endif
  } state_t;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q,    wstrb_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q,  w_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [1:0]            resp_q,     resp_d;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // cnt_q holds the number of wait cycles already spent in WR_RSP/RD_RSP;
  // the response times out in the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             timeout_q,  timeout_d;
  logic             drain_wr_q, drain_wr_d;   // 1: late beat is a B, 0: an R
`endif

  // Output mapping: handshake qualifiers decode from state, payloads come
  // straight from registers so they are stable while valid is high.
  // cmd_ready is also gated by rst_n so every output reads 0 while in reset.
  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_resp  = resp_q;
  assign bus.aw_addr   = addr_q;
  assign bus.aw_prot   = 3'b000;
  assign bus.aw_valid  = aw_valid_q;
  assign bus.w_data    = wdata_q;
  assign bus.w_strb    = wstrb_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.ar_addr   = addr_q;
  assign bus.ar_prot   = 3'b000;
  assign bus.ar_valid  = (state_q == RD_REQ);
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  assign bus.rsp_timeout = timeout_q;
  assign bus.b_ready     = (state_q == WR_RSP) || ((state_q == DRAIN) &&  drain_wr_q);
  assign bus.r_ready     = (state_q == RD_RSP) || ((state_q == DRAIN) && !drain_wr_q);
`else
  assign bus.rsp_timeout = 1'b0;
  assign bus.b_ready     = (state_q == WR_RSP);
  assign bus.r_ready     = (state_q == RD_RSP);
`endif

  // Next-state and next-register values for the transaction sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    drain_wr_d = drain_wr_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          if (bus.cmd_write) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = WR_REQ;
          end else begin
            state_d = RD_REQ;
          end
        end
      end

      // AW and W complete independently; leave once both are accepted.
      WR_REQ: begin
        if (bus.aw_ready) aw_valid_d = 1'b0;
        if (bus.w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d = WR_RSP;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      // A B beat in the expiry cycle still wins over the timeout.
      WR_RSP: begin
        if (bus.b_valid) begin
          resp_d    = bus.b_resp;
          rdata_d   = '0;
          state_d   = RSP;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          resp_d     = 2'b10;
          rdata_d    = '0;
          timeout_d  = 1'b1;
          drain_wr_d = 1'b1;
          state_d    = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      RD_REQ: begin
        if (bus.ar_ready) begin
          state_d = RD_RSP;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      RD_RSP: begin
        if (bus.r_valid) begin
          resp_d    = bus.r_resp;
          rdata_d   = bus.r_data;
          state_d   = RSP;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          resp_d     = 2'b10;
          rdata_d    = '0;
          timeout_d  = 1'b1;
          drain_wr_d = 1'b0;
          state_d    = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      RSP: begin
        if (bus.rsp_ready) begin
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
          state_d = timeout_q ? DRAIN : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
      // Swallow the late beat of a timed-out transaction before going idle.
      DRAIN: begin
        if (drain_wr_q ? bus.b_valid : bus.r_valid) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      // NOTE: payload registers are reset as well because they drive the
      // address, data and response outputs, which must read 0 in reset.
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= '0;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      drain_wr_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      drain_wr_q <= drain_wr_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master. A configurable AXI-Lite slave model
// answers the bus; each command pushes its hand-computed response into a
// scoreboard queue that an independent monitor pops at every rsp handshake.
// Response latency is counted from the cycle of the cmd handshake to the
// first cycle rsp_valid is seen.
module tb_axi_lite_cmd_master;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          timeout;
    int            lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_cmd_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   cmd_cyc = 0;
  int   rsp_hs_cyc = 0;

  // Slave and consumer knobs
  int            aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit            b_en = 1'b1, r_en = 1'b1;
  logic [1:0]    b_resp_val = 2'b00, r_resp_val = 2'b00;
  logic [DW-1:0] r_data_val = '0;
  int            rsp_hold = 0;
  int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 128'({bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout, bus.aw_valid,
                                bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}), 128'(0));
    check({tag, "_addr"}, 128'({bus.aw_addr, bus.ar_addr}), 128'(0));
    check({tag, "_data"}, 128'({bus.w_data, bus.w_strb, bus.rsp_rdata, bus.rsp_resp,
                                bus.aw_prot, bus.ar_prot}), 128'(0));
  endtask

  // Must be called at a falling edge. Holds cmd_valid until accepted and
  // returns at the falling edge of the cycle after the handshake.
  task automatic send_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input exp_t e);
    bit ok = 1'b0;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("cmd_accept_bound", 128'(bus.cmd_ready), 128'(1));
    cmd_cyc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
  endtask

  // Wait until every expected response has been seen (and optionally the
  // master is idle again), bounded by a cycle budget.
  task automatic wait_done(input bit need_idle);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && (!need_idle || bus.cmd_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("response_wait_bound", 128'(sb_q.size()), 128'(0));
  endtask

  // AXI-Lite slave model. At each falling edge it first books the handshakes
  // that completed on the previous rising edge, then sets the next readies
  // and valids according to the wait knobs.
  initial begin : slave
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    {aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_valid  = 1'b0; bus.b_resp  = 2'b00;
    bus.r_valid  = 1'b0; bus.r_resp  = 2'b00; bus.r_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
        bus.b_valid  = 1'b0; bus.r_valid = 1'b0;
      end else begin
        if (aw_fire) aw_hs++;
        if (w_fire)  w_hs++;
        if (ar_fire) ar_hs++;
        if (b_fire) begin b_hs++; bus.b_valid = 1'b0; end
        if (r_fire) begin r_hs++; bus.r_valid = 1'b0; end

        if (bus.aw_valid) begin
          if (aw_cnt >= aw_wait) bus.aw_ready = 1'b1;
          else begin bus.aw_ready = 1'b0; aw_cnt++; end
        end else begin bus.aw_ready = 1'b0; aw_cnt = 0; end

        if (bus.w_valid) begin
          if (w_cnt >= w_wait) bus.w_ready = 1'b1;
          else begin bus.w_ready = 1'b0; w_cnt++; end
        end else begin bus.w_ready = 1'b0; w_cnt = 0; end

        if (bus.ar_valid) begin
          if (ar_cnt >= ar_wait) bus.ar_ready = 1'b1;
          else begin bus.ar_ready = 1'b0; ar_cnt++; end
        end else begin bus.ar_ready = 1'b0; ar_cnt = 0; end

        if (!bus.b_valid && b_en && aw_hs > b_hs && w_hs > b_hs) begin
          if (b_cnt >= b_wait) begin
            bus.b_valid = 1'b1; bus.b_resp = b_resp_val; b_cnt = 0;
          end else b_cnt++;
        end

        if (!bus.r_valid && r_en && ar_hs > r_hs) begin
          if (r_cnt >= r_wait) begin
            bus.r_valid = 1'b1; bus.r_data = r_data_val; bus.r_resp = r_resp_val; r_cnt = 0;
          end else r_cnt++;
        end

        aw_fire = bus.aw_valid && bus.aw_ready;
        w_fire  = bus.w_valid  && bus.w_ready;
        ar_fire = bus.ar_valid && bus.ar_ready;
        b_fire  = bus.b_valid  && bus.b_ready;
        r_fire  = bus.r_valid  && bus.r_ready;
      end
    end
  end

  // Response consumer and scoreboard monitor.
  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] snap_rdata;
    logic [1:0]    snap_resp;
    logic          snap_tmo;
    bit            seen;
    int            first_cyc, hold_cnt;
    seen = 1'b0; first_cyc = 0; hold_cnt = 0;
    snap_rdata = '0; snap_resp = '0; snap_tmo = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0; hold_cnt = 0; bus.rsp_ready = 1'b0;
      end else if (bus.rsp_valid) begin
        if (!seen) begin
          seen = 1'b1; first_cyc = cyc; hold_cnt = 0;
          snap_rdata = bus.rsp_rdata; snap_resp = bus.rsp_resp; snap_tmo = bus.rsp_timeout;
        end else begin
          check("rsp_stable_rdata", 128'(bus.rsp_rdata), 128'(snap_rdata));
          check("rsp_stable_resp_tmo", 128'({bus.rsp_resp, bus.rsp_timeout}),
                128'({snap_resp, snap_tmo}));
        end
        if (hold_cnt < rsp_hold) begin
          bus.rsp_ready = 1'b0;
          hold_cnt++;
        end else begin
          bus.rsp_ready = 1'b1;
          rsp_hs_cyc = cyc;
          seen = 1'b0;
          if (sb_q.size() == 0) begin
            check("rsp_with_empty_scoreboard", 128'(sb_q.size()), 128'(1));
          end else begin
            e = sb_q.pop_front();
            check("rsp_rdata",   128'(bus.rsp_rdata),   128'(e.rdata));
            check("rsp_resp",    128'(bus.rsp_resp),    128'(e.resp));
            check("rsp_timeout", 128'(bus.rsp_timeout), 128'(e.timeout));
            if (e.lat >= 0) check("rsp_latency", 128'(first_cyc - cmd_cyc), 128'(e.lat));
          end
        end
      end else begin
        bus.rsp_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion, expected end of stimulus before 400000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;   bus.cmd_wdata = '0; bus.cmd_wstrb = '0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    #1 check("reset_release_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    @(negedge clk);

    // Zero-wait write: AW and W together in cycle 1, response in cycle 3
    send_cmd(1'b1, 64'h2000_0010, 32'hDEAD_BEEF, 4'hF, '{32'h0, 2'b00, 1'b0, 3});
    check("wr0_aw_w_valid", 128'({bus.aw_valid, bus.w_valid}), 128'(2'b11));
    check("wr0_aw_addr", 128'(bus.aw_addr), 128'(64'h2000_0010));
    check("wr0_w_data_strb", 128'({bus.w_data, bus.w_strb}), 128'({32'hDEAD_BEEF, 4'hF}));
    wait_done(1'b1);

    // AW held off 3 cycles, W accepted first; DECERR forwarded
    aw_wait = 3; b_resp_val = 2'b11; b0 = b_hs;
    send_cmd(1'b1, 64'h2000_0014, 32'hCAFE_F00D, 4'h3, '{32'h0, 2'b11, 1'b0, 6});
    check("wr1_both_valid", 128'({bus.aw_valid, bus.w_valid}), 128'(2'b11));
    @(negedge clk);
    check("wr1_w_dropped_aw_held", 128'({bus.aw_valid, bus.w_valid}), 128'(2'b10));
    wait_done(1'b1);
    check("wr1_single_b", 128'(b_hs - b0), 128'(1));
    aw_wait = 0; b_resp_val = 2'b00;

    // W held off 2 cycles, AW accepted first
    w_wait = 2;
    send_cmd(1'b1, 64'h2000_0018, 32'h0102_0304, 4'h8, '{32'h0, 2'b00, 1'b0, 5});
    @(negedge clk);
    check("wr2_aw_dropped_w_held", 128'({bus.aw_valid, bus.w_valid}), 128'(2'b01));
    wait_done(1'b1);
    w_wait = 0;

    // Read returning SLVERR with data
    r_data_val = 32'h1234_5678; r_resp_val = 2'b10;
    send_cmd(1'b0, 64'h2000_0008, 32'h0, 4'h0, '{32'h1234_5678, 2'b10, 1'b0, 3});
    check("rd0_ar", 128'({bus.ar_valid, bus.ar_addr}), 128'({1'b1, 64'h2000_0008}));
    @(negedge clk);
    check("rd0_cmd_ready_busy", 128'(bus.cmd_ready), 128'(0));
    wait_done(1'b1);

    // Read with R delayed 2 cycles
    r_data_val = 32'hA5A5_0F0F; r_resp_val = 2'b00; r_wait = 2;
    send_cmd(1'b0, 64'h2000_0004, 32'h0, 4'h0, '{32'hA5A5_0F0F, 2'b00, 1'b0, 5});
    wait_done(1'b1);
    r_wait = 0;

    // Response back-pressure with a second command waiting upstream
    r_data_val = 32'h0BAD_F00D; rsp_hold = 5;
    send_cmd(1'b0, 64'h2000_000C, 32'h0, 4'h0, '{32'h0BAD_F00D, 2'b00, 1'b0, 3});
    send_cmd(1'b1, 64'h2000_0020, 32'h1111_2222, 4'hF, '{32'h0, 2'b00, 1'b0, 3});
    rsp_hold = 0;
    check("bp_next_cmd_cycle", 128'(cmd_cyc), 128'(rsp_hs_cyc + 1));
    wait_done(1'b1);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    // B never returns: timeout response, then the late B is drained
    b_en = 1'b0; b0 = b_hs;
    send_cmd(1'b1, 64'h2000_0030, 32'h55AA_55AA, 4'hF, '{32'h0, 2'b10, 1'b1, 2 + TMO});
    wait_done(1'b0);
    repeat (20) @(negedge clk);
    check("tmo_drain_b_ready", 128'({bus.b_ready, bus.cmd_ready}), 128'(2'b10));
    b_en = 1'b1;
    repeat (5) @(negedge clk);
    check("tmo_late_b_consumed", 128'(b_hs - b0), 128'(1));
    check("tmo_back_to_idle", 128'(bus.cmd_ready), 128'(1));
    r_data_val = 32'h600D_600D;
    send_cmd(1'b0, 64'h2000_0034, 32'h0, 4'h0, '{32'h600D_600D, 2'b00, 1'b0, 3});
    wait_done(1'b1);
`endif

    // Reset while waiting for R
    r_en = 1'b0;
    send_cmd(1'b0, 64'h2000_0040, 32'h0, 4'h0, '{32'h0, 2'b00, 1'b0, -1});
    @(negedge clk);
    check("rst_mid_r_ready", 128'(bus.r_ready), 128'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    sb_q.delete();
    r_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("rst_mid_release_cmd_ready", 128'(bus.cmd_ready), 128'(1));
    @(negedge clk);
    send_cmd(1'b1, 64'h2000_0044, 32'h7777_8888, 4'hC, '{32'h0, 2'b00, 1'b0, 3});
    wait_done(1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
